seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_if.sv | 38 +++
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
//   Request/response bundle for seq_alu.
//
//   Request channel  (master -> slave): in_valid, alu_op, func, a, b
//                    (slave -> master): in_ready
//   Response channel (slave -> master): out_valid, result, zero, illegal
//                    (master -> slave): out_ready
//
//   WIDTH must match the WIDTH parameter of the seq_alu bound to it.
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    // Requester / consumer side.
    modport master (
        output in_valid, alu_op, func, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    // ALU side.
    modport slave (
        input  in_valid, alu_op, func, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Sequential ALU with a valid/ready request port and a valid/ready result
//   port. One request is in flight at a time. add/sub/and/or/slt and illegal
//   opcodes complete in one cycle; multiply (MUL_EN=1) is an iterative
//   shift-add taking WIDTH cycles in the MUL state.
//
// Parameters
//   WIDTH   operand/result width, 4..64
//   MUL_EN  1 enables the multiply opcode, 0 decodes it as illegal
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     seq_alu_if.slave:
//             in_valid/in_ready      request handshake
//             alu_op, func, a, b     request payload
//             out_valid/out_ready    result handshake
//             result, zero, illegal  result payload, stable while out_valid
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    seq_alu_if.slave   bus
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_SLT,
        OP_MUL,
        OP_ILL
    } op_e;

    state_e           state_q, state_d;
    op_e              op_dec;
    logic [WIDTH-1:0] alu_res;
    logic             accept;

    logic [WIDTH-1:0] res_q;     // result register, doubles as mul accumulator
    logic             ill_q;
    logic [WIDTH-1:0] mcand_q;   // multiplicand, shifted left each MUL cycle
    logic [WIDTH-1:0] mplier_q;  // multiplier, shifted right each MUL cycle
    logic [CW-1:0]    cnt_q;

    // Only func[3:0] is decoded; the upper bits are deliberately ignored.
    logic unused_func;
    assign unused_func = ^bus.func[5:4];

    // -------------------------------------------------------------------------
    // Opcode decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable written in always_comb gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        op_dec = OP_ILL;
        unique case (bus.alu_op)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (bus.func[3:0])
                    4'h0:    op_dec = OP_ADD;
                    4'h2:    op_dec = OP_SUB;
                    4'h4:    op_dec = OP_AND;
                    4'h5:    op_dec = OP_OR;
                    4'hA:    op_dec = OP_SLT;
                    4'h8:    op_dec = MUL_EN ? OP_MUL : OP_ILL;
                    default: op_dec = OP_ILL;
                endcase
            end
            default: op_dec = OP_ILL;
        endcase
    end

    // -------------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live request operands and
    // captured into res_q at acceptance. Illegal opcodes yield zero.
    // -------------------------------------------------------------------------
    always_comb begin
        alu_res = '0;
        case (op_dec)
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
            default: alu_res = '0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM: next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        accept        = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (bus.in_valid) begin
                    state_d = (op_dec == OP_MUL) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                // The final partial product lands on the edge that leaves MUL.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    //   IDLE+accept : capture single-cycle result, or load the multiply
    //   MUL         : one shift-add partial product per cycle
    //   DONE        : hold everything until the result handshake
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q    <= '0;
            ill_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (accept) begin
                cnt_q <= '0;
                ill_q <= (op_dec == OP_ILL);
                if (op_dec == OP_MUL) begin
                    res_q    <= '0;
                    mcand_q  <= bus.a;
                    mplier_q <= bus.b;
                end else begin
                    res_q <= alu_res;
                end
            end else if (state_q == S_MUL) begin
                // Bits shifted out of mcand_q only affect product bits at or
                // above WIDTH, which are discarded anyway.
                if (mplier_q[0]) begin
                    res_q <= res_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.result  = res_q;
    assign bus.zero    = (res_q == '0);
    assign bus.illegal = ill_q;

endmodule
